sdram_arbiter: RTL and testbench

Shares the single SDRAMBus command port among the five SDRAM clients of the a cappella core: record, play, mix, pitch and loaddata. It replaces the hard-wired play/record assignment in the core top. It grants one whole transaction at a time and latches the winner's command for the full transaction. The finished pulse and read data are routed back to the winner only. Record and play have strict priority for real-time audio; the three offline clients share the remaining bandwidth round-robin, with an age-based anti-starvation override.

---
 rtl/sdram_arbiter.sv | 176 +++++++++++++++++
 tb/tb_sdram_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the single SDRAMBus command port among five clients.
// Ports 0/1 (audio) have strict priority; ports 2..4 round-robin with an age override.
module sdram_arbiter #(
   parameter int unsigned AGE_LIMIT = 1024
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic [4:0]     req_read,
   input  logic [4:0]     req_write,
   input  logic [114:0]   req_addr,
   input  logic [159:0]   req_writedata,
   output logic [4:0]     req_finished,
   output logic [31:0]    req_readdata,
   output logic           sdram_read,
   output logic           sdram_write,
   output logic [22:0]    sdram_addr,
   output logic [31:0]    sdram_writedata,
   input  logic [31:0]    sdram_readdata,
   input  logic           sdram_finished,
   output logic           busy,
   output logic [2:0]     grant_id
);
   localparam logic [15:0] AGE_MAX = 16'(AGE_LIMIT);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state_q, state_d;
   logic             sdram_read_q, sdram_read_d;
   logic             sdram_write_q, sdram_write_d;
   logic [22:0]      sdram_addr_q, sdram_addr_d;
   logic [31:0]      sdram_writedata_q, sdram_writedata_d;
   logic [4:0]       req_finished_q, req_finished_d;
   logic [31:0]      req_readdata_q, req_readdata_d;
   logic [2:0]       grant_id_q, grant_id_d;
   logic [2:0]       rr_ptr_q, rr_ptr_d;
   logic [2:0][15:0] age_q, age_d;

   logic [4:0]  pending, aged;
   logic        win_valid, aged_found, rr_found, grant_now;
   logic [2:0]  win_id, aged_id, rr_id, cand;
   logic [22:0] sel_addr;
   logic [31:0] sel_wdata;

   assign pending = req_read | req_write;

   always_comb begin : arbitrate
      aged = '0;
      for (int unsigned k = 0; k < 3; k++)
         aged[k + 2] = pending[k + 2] && (age_q[k] == AGE_MAX);

      aged_found = 1'b0;
      rr_found   = 1'b0;
      aged_id    = 3'd2;
      rr_id      = 3'd2;
      cand       = 3'd2;
      // Walk the offline ports starting at rr_ptr, wrapping 4 -> 2.
      for (int unsigned i = 0; i < 3; i++) begin
         cand = rr_ptr_q + 3'(i);
         if (cand > 3'd4)
            cand = cand - 3'd3;
         if (!aged_found && aged[cand]) begin
            aged_found = 1'b1;
            aged_id    = cand;
         end
         if (!rr_found && pending[cand]) begin
            rr_found = 1'b1;
            rr_id    = cand;
         end
      end

      win_valid = |pending;
      if (aged_found)
         win_id = aged_id;
      else if (pending[0])
         win_id = 3'd0;
      else if (pending[1])
         win_id = 3'd1;
      else
         win_id = rr_id;

      sel_addr  = '0;
      sel_wdata = '0;
      for (int unsigned k = 0; k < 5; k++) begin
         if (win_id == 3'(k)) begin
            sel_addr  = req_addr[23*k +: 23];
            sel_wdata = req_writedata[32*k +: 32];
         end
      end
   end

   always_comb begin : fsm
      state_d           = state_q;
      sdram_read_d      = sdram_read_q;
      sdram_write_d     = sdram_write_q;
      sdram_addr_d      = sdram_addr_q;
      sdram_writedata_d = sdram_writedata_q;
      req_finished_d    = '0;
      req_readdata_d    = req_readdata_q;
      grant_id_d        = grant_id_q;
      rr_ptr_d          = rr_ptr_q;
      grant_now         = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_valid) begin
               grant_now         = 1'b1;
               state_d           = BUSY;
               grant_id_d        = win_id;
               sdram_write_d     = req_write[win_id];
               sdram_read_d      = ~req_write[win_id];
               sdram_addr_d      = sel_addr;
               sdram_writedata_d = sel_wdata;
               if (win_id >= 3'd2)
                  rr_ptr_d = (win_id == 3'd4) ? 3'd2 : win_id + 3'd1;
            end
         end
         BUSY: begin
            if (sdram_finished) begin
               req_finished_d[grant_id_q] = 1'b1;
               req_readdata_d             = sdram_readdata;
               sdram_read_d               = 1'b0;
               sdram_write_d              = 1'b0;
               state_d                    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The port being served still holds its request while BUSY; it does not age.
   always_comb begin : ages
      age_d = age_q;
      for (int unsigned k = 0; k < 3; k++) begin
         if (!pending[k + 2] || (grant_now && win_id == 3'(k + 2)) ||
             (state_q == BUSY && grant_id_q == 3'(k + 2)))
            age_d[k] = '0;
         else if (age_q[k] != AGE_MAX)
            age_d[k] = age_q[k] + 16'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q           <= IDLE;
         sdram_read_q      <= 1'b0;
         sdram_write_q     <= 1'b0;
         sdram_addr_q      <= '0;
         sdram_writedata_q <= '0;
         req_finished_q    <= '0;
         req_readdata_q    <= '0;
         grant_id_q        <= '0;
         rr_ptr_q          <= 3'd2;
         age_q             <= '0;
      end else begin
         state_q           <= state_d;
         sdram_read_q      <= sdram_read_d;
         sdram_write_q     <= sdram_write_d;
         sdram_addr_q      <= sdram_addr_d;
         sdram_writedata_q <= sdram_writedata_d;
         req_finished_q    <= req_finished_d;
         req_readdata_q    <= req_readdata_d;
         grant_id_q        <= grant_id_d;
         rr_ptr_q          <= rr_ptr_d;
         age_q             <= age_d;
      end
   end

   assign sdram_read      = sdram_read_q;
   assign sdram_write     = sdram_write_q;
   assign sdram_addr      = sdram_addr_q;
   assign sdram_writedata = sdram_writedata_q;
   assign req_finished    = req_finished_q;
   assign req_readdata    = req_readdata_q;
   assign grant_id        = grant_id_q;
   assign busy            = (state_q == BUSY);

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed scenarios with grant/finish scoreboards and a latency-driven bus model.
module tb_sdram_arbiter;
   logic           i_clk = 1'b0;
   logic           i_rst;
   logic [4:0]     req_read, req_write;
   logic [114:0]   req_addr;
   logic [159:0]   req_writedata;
   logic [4:0]     req_finished;
   logic [31:0]    req_readdata;
   logic           sdram_read, sdram_write;
   logic [22:0]    sdram_addr;
   logic [31:0]    sdram_writedata;
   logic [31:0]    sdram_readdata;
   logic           sdram_finished;
   logic           busy;
   logic [2:0]     grant_id;

   typedef struct {
      int unsigned id;
      bit          wr;
      logic [31:0] rdata;
   } txn_t;

   txn_t        exp_grant[$];
   txn_t        exp_fin[$];
   int unsigned tests = 0;
   int unsigned fails = 0;
   int unsigned bus_cnt = 0;
   int unsigned bus_lat = 2;
   bit          bus_en = 1'b1;
   bit          prev_busy = 1'b0;
   logic [4:0]  cont = '0;
   logic [4:0]  last_fin = '0;

   sdram_arbiter #(.AGE_LIMIT(8)) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .req_read        (req_read),
      .req_write       (req_write),
      .req_addr        (req_addr),
      .req_writedata   (req_writedata),
      .req_finished    (req_finished),
      .req_readdata    (req_readdata),
      .sdram_read      (sdram_read),
      .sdram_write     (sdram_write),
      .sdram_addr      (sdram_addr),
      .sdram_writedata (sdram_writedata),
      .sdram_readdata  (sdram_readdata),
      .sdram_finished  (sdram_finished),
      .busy            (busy),
      .grant_id        (grant_id)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_port(input int unsigned k, input logic [22:0] a, input logic [31:0] d);
      req_addr[23*k +: 23]      = a;
      req_writedata[32*k +: 32] = d;
   endtask

   task automatic expect_grant(input int unsigned id, input bit wr);
      txn_t t;
      t.id    = id;
      t.wr    = wr;
      t.rdata = sdram_readdata;
      exp_grant.push_back(t);
   endtask

   // One clock: sample after the edge, score grants/finishes, then drive the bus model.
   task automatic tick();
      txn_t       t;
      logic [4:0] oh;
      @(posedge i_clk);
      #1;
      check("cmd_matches_busy", {31'b0, sdram_read | sdram_write}, {31'b0, busy});
      if (busy && !prev_busy) begin
         tests++;
         assert (exp_grant.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_grant: observed port %0d expected no grant", grant_id);
         end
         if (exp_grant.size() != 0) begin
            t = exp_grant.pop_front();
            check("grant_id", {29'b0, grant_id}, t.id);
            check("grant_write", {31'b0, sdram_write}, {31'b0, t.wr});
            check("grant_read", {31'b0, sdram_read}, {31'b0, ~t.wr});
            exp_fin.push_back(t);
         end
      end
      prev_busy = busy;
      last_fin  = req_finished;
      if (req_finished != '0) begin
         tests++;
         assert (exp_fin.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_finish: observed %b expected 00000", req_finished);
         end
         if (exp_fin.size() != 0) begin
            t  = exp_fin.pop_front();
            oh = 5'd1 << t.id;
            check("finished_onehot", {27'b0, req_finished}, {27'b0, oh});
            check("readdata", req_readdata, t.rdata);
         end
         req_read  = req_read & ~(req_finished & ~cont);
         req_write = req_write & ~(req_finished & ~cont);
      end
      if (bus_en) begin
         if (sdram_read || sdram_write) begin
            bus_cnt++;
            sdram_finished = (bus_cnt == bus_lat);
         end else begin
            bus_cnt        = 0;
            sdram_finished = 1'b0;
         end
      end
   endtask

   task automatic wait_idle(input string tag);
      int unsigned n = 0;
      while ((exp_grant.size() != 0 || exp_fin.size() != 0 || busy) && n < 400) begin
         tick();
         n++;
      end
      tests++;
      assert (n < 400) else begin
         fails++;
         $error("FAIL %s_timeout: observed %0d outstanding expected 0", tag,
                exp_grant.size() + exp_fin.size());
      end
      tick();
   endtask

   initial begin
      i_rst          = 1'b1;
      req_read       = '0;
      req_write      = '0;
      req_addr       = '0;
      req_writedata  = '0;
      sdram_readdata = '0;
      sdram_finished = 1'b0;
      #2;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_grant_id", {29'b0, grant_id}, 32'd0);
      check("rst_read", {31'b0, sdram_read}, 32'd0);
      check("rst_write", {31'b0, sdram_write}, 32'd0);
      check("rst_addr", {9'b0, sdram_addr}, 32'd0);
      check("rst_wdata", sdram_writedata, 32'd0);
      check("rst_finished", {27'b0, req_finished}, 32'd0);
      check("rst_readdata", req_readdata, 32'd0);
      tick();
      i_rst = 1'b0;
      tick();

      // Single read on port 1, five-cycle bus latency.
      set_port(1, 23'h00ABCD, 32'h0);
      sdram_readdata = 32'hDEADBEEF;
      bus_lat        = 5;
      expect_grant(1, 1'b0);
      req_read[1] = 1'b1;
      tick();
      check("single_read_cmd", {31'b0, sdram_read}, 32'd1);
      check("single_read_addr", {9'b0, sdram_addr}, 32'h00ABCD);
      wait_idle("single_read");

      // Audio priority: 0 and 1 ahead of offline port 3.
      bus_lat        = 2;
      sdram_readdata = 32'h0A0D10F0;
      set_port(0, 23'h000010, 32'h0);
      set_port(3, 23'h000030, 32'h0);
      expect_grant(0, 1'b0);
      expect_grant(1, 1'b0);
      expect_grant(3, 1'b0);
      req_read[0] = 1'b1;
      req_read[1] = 1'b1;
      req_read[3] = 1'b1;
      wait_idle("audio_priority");

      // Anti-starvation: port 4 overrides a continuously requesting port 0 once aged.
      sdram_readdata = 32'h5A5A0004;
      cont[0]        = 1'b1;
      expect_grant(0, 1'b0);
      expect_grant(0, 1'b0);
      expect_grant(0, 1'b0);
      expect_grant(4, 1'b0);
      expect_grant(0, 1'b0);
      req_read[0] = 1'b1;
      req_read[4] = 1'b1;
      for (int i = 0; i < 200 && exp_grant.size() > 1; i++)
         tick();
      cont[0] = 1'b0;
      wait_idle("anti_starvation");

      // Round-robin among offline ports.
      bus_lat        = 3;
      sdram_readdata = 32'h00C0FFEE;
      cont[4:2]      = 3'b111;
      for (int r = 0; r < 2; r++) begin
         expect_grant(2, 1'b0);
         expect_grant(3, 1'b0);
         expect_grant(4, 1'b0);
      end
      req_read[4:2] = 3'b111;
      for (int i = 0; i < 200 && exp_grant.size() != 0; i++)
         tick();
      req_read[3:2] = 2'b00;
      cont          = '0;
      wait_idle("round_robin");

      // Read and write both high: write first, then the read as a new transaction.
      bus_lat        = 2;
      sdram_readdata = 32'h11112222;
      cont[0]        = 1'b1;
      set_port(0, 23'h000123, 32'hCAFEF00D);
      expect_grant(0, 1'b1);
      expect_grant(0, 1'b0);
      req_read[0]  = 1'b1;
      req_write[0] = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (last_fin[0])
            break;
      end
      req_write[0] = 1'b0;
      cont[0]      = 1'b0;
      wait_idle("read_write_both");

      // Request dropped mid-transaction: command and latched fields persist.
      bus_lat        = 4;
      sdram_readdata = 32'h87654321;
      set_port(2, 23'h7FFFFF, 32'h12345678);
      expect_grant(2, 1'b1);
      req_write[2] = 1'b1;
      tick();
      check("drop_write_cmd", {31'b0, sdram_write}, 32'd1);
      check("drop_addr", {9'b0, sdram_addr}, 32'h7FFFFF);
      check("drop_wdata", sdram_writedata, 32'h12345678);
      tick();
      req_write[2] = 1'b0;
      set_port(2, 23'h0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("drop_hold_write", {31'b0, sdram_write}, 32'd1);
         check("drop_hold_addr", {9'b0, sdram_addr}, 32'h7FFFFF);
         check("drop_hold_wdata", sdram_writedata, 32'h12345678);
      end
      wait_idle("drop_mid");

      // sdram_finished while idle produces no pulse.
      bus_en         = 1'b0;
      sdram_finished = 1'b1;
      tick();
      check("idle_finish_ignored", {27'b0, req_finished}, 32'd0);
      check("idle_finish_busy", {31'b0, busy}, 32'd0);
      sdram_finished = 1'b0;
      tick();
      bus_en = 1'b1;

      // Reset during BUSY, then priority and rr_ptr restart from reset values.
      bus_lat        = 50;
      sdram_readdata = 32'h0BADF00D;
      set_port(3, 23'h0F0F0F, 32'hA5A5A5A5);
      set_port(4, 23'h000444, 32'h0);
      expect_grant(3, 1'b1);
      req_write[3] = 1'b1;
      tick();
      tick();
      req_read[1] = 1'b1;
      req_read[4] = 1'b1;
      i_rst       = 1'b1;
      #1;
      check("midrst_write", {31'b0, sdram_write}, 32'd0);
      check("midrst_busy", {31'b0, busy}, 32'd0);
      check("midrst_finished", {27'b0, req_finished}, 32'd0);
      check("midrst_grant_id", {29'b0, grant_id}, 32'd0);
      check("midrst_addr", {9'b0, sdram_addr}, 32'd0);
      check("midrst_wdata", sdram_writedata, 32'd0);
      exp_fin.delete();
      bus_cnt        = 0;
      sdram_finished = 1'b0;
      prev_busy      = 1'b0;
      bus_lat        = 2;
      expect_grant(1, 1'b0);
      expect_grant(3, 1'b1);
      expect_grant(4, 1'b0);
      tick();
      i_rst = 1'b0;
      wait_idle("reset_mid");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
